// File: rtl/mul6_operand_divider.sv
// Sequential restoring divider: recovers a multiplier operand from its product and the other operand.
// Optional saturating result counters are built when MUL6_DIV_PERF_CNT_EN is defined.
module mul6_operand_divider #(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_prod,
  input  logic [W-1:0]   in_opa,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_quo,
  output logic [W-1:0]   out_rem,
  output logic           out_ovf,
  output logic           out_dbz,
  output logic           busy
`ifdef MUL6_DIV_PERF_CNT_EN
  ,
  input  logic           cnt_clr,
  output logic [15:0]    cnt_done,
  output logic [15:0]    cnt_ovf
`endif
);

  localparam int SW = $clog2(2 * W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [2*W-1:0] dvd;
  logic [2*W-1:0] quo;
  logic [W-1:0]   dvs;
  logic [W-1:0]   rem;
  logic [SW-1:0]  step;
  logic [W:0]     shifted;
  logic [W:0]     rem_step;
  logic [2*W-1:0] quo_step;
  logic           qbit;
  logic           last_step;
  logic           accept;
  logic           handshake;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_ready && in_valid;
  assign handshake = out_valid && out_ready;
  assign last_step = (step == SW'(2 * W - 1));

  // The W+1-bit partial remainder only exists transiently: after each restore it is below the divisor.
  always_comb begin
    shifted  = {rem, dvd[2*W-1]};
    qbit     = (shifted >= {1'b0, dvs});
    rem_step = qbit ? (shifted - {1'b0, dvs}) : shifted;
    quo_step = {quo[2*W-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (in_opa == '0) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      step    <= '0;
      out_quo <= '0;
      out_rem <= '0;
      out_ovf <= 1'b0;
      out_dbz <= 1'b0;
    end else begin
      if (accept) begin
        dvd  <= in_prod;
        dvs  <= in_opa;
        rem  <= '0;
        quo  <= '0;
        step <= '0;
        if (in_opa == '0) begin
          out_quo <= '1;
          out_rem <= '0;
          out_ovf <= 1'b0;
          out_dbz <= 1'b1;
        end
      end else if (state == CALC) begin
        dvd  <= dvd << 1;
        rem  <= rem_step[W-1:0];
        quo  <= quo_step;
        step <= step + SW'(1);
        if (last_step) begin
          out_quo <= quo_step[W-1:0];
          out_rem <= rem_step[W-1:0];
          out_ovf <= |quo_step[2*W-1:W];
          out_dbz <= 1'b0;
        end
      end
    end
  end

`ifdef MUL6_DIV_PERF_CNT_EN
  // Clear wins over a coincident increment; both counters stick at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_done <= '0;
      cnt_ovf  <= '0;
    end else if (cnt_clr) begin
      cnt_done <= '0;
      cnt_ovf  <= '0;
    end else if (handshake) begin
      if (cnt_done != 16'hFFFF) cnt_done <= cnt_done + 16'd1;
      if (out_ovf && (cnt_ovf != 16'hFFFF)) cnt_ovf <= cnt_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul6_operand_divider.sv
// Scoreboard bench for mul6_operand_divider: arithmetic reference model, queued expectations, handshake monitor.
// Counter checks are included when MUL6_DIV_PERF_CNT_EN is defined.
module tb_mul6_operand_divider;

  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_prod;
  logic [W-1:0]   in_opa;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_quo;
  logic [W-1:0]   out_rem;
  logic           out_ovf;
  logic           out_dbz;
  logic           busy;
`ifdef MUL6_DIV_PERF_CNT_EN
  logic           cnt_clr;
  logic [15:0]    cnt_done;
  logic [15:0]    cnt_ovf;
`endif

  int   tests  = 0;
  int   failed = 0;
  exp_t exp_q[$];

  mul6_operand_divider #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_opa(in_opa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quo(out_quo), .out_rem(out_rem), .out_ovf(out_ovf), .out_dbz(out_dbz),
    .busy(busy)
`ifdef MUL6_DIV_PERF_CNT_EN
    , .cnt_clr(cnt_clr), .cnt_done(cnt_done), .cnt_ovf(cnt_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Division as plain integer arithmetic on the operands.
  function automatic exp_t refModel(input int p, input int a);
    exp_t e;
    int q;
    if (a == 0) begin
      e.quo = '1; e.rem = '0; e.ovf = 1'b0; e.dbz = 1'b1;
    end else begin
      q     = p / a;
      e.quo = W'(q % (1 << W));
      e.rem = W'(p % a);
      e.ovf = (q >= (1 << W));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input int a);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("accept_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_prod  = (2*W)'(p);
    in_opa   = W'(a);
    exp_q.push_back(refModel(p, a));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_prod  = (2*W)'($urandom);
    in_opa   = W'($urandom);
  endtask

  task automatic waitValid(input int lat);
    int k = 1;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1; k++;
    end
    checkOutput("latency", k, lat);
  endtask

  task automatic runOp(input int p, input int a, input int hold);
    out_ready = (hold == 0);
    applyStimulus(p, a);
    waitValid((a == 0) ? 1 : 2*W + 1);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("out_valid_after", int'(out_valid), 0);
    checkOutput("in_ready_after", int'(in_ready), 1);
  endtask

  // Monitor: every output handshake consumes the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("quo", int'(out_quo), int'(e.quo));
          checkOutput("rem", int'(out_rem), int'(e.rem));
          checkOutput("ovf", int'(out_ovf), int'(e.ovf));
          checkOutput("dbz", int'(out_dbz), int'(e.dbz));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_opa = '0; out_ready = 1'b1;
`ifdef MUL6_DIV_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_quo", int'(out_quo), 0);
    checkOutput("rst_rem", int'(out_rem), 0);
    checkOutput("rst_ovf", int'(out_ovf), 0);
    checkOutput("rst_dbz", int'(out_dbz), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp(35, 5, 0);
    runOp(100, 7, 0);
    runOp(4095, 63, 0);
    runOp(200, 0, 0);

    // Backpressure with an ignored request while the result is held.
    out_ready = 1'b0;
    e = refModel(100, 7);
    applyStimulus(100, 7);
    waitValid(2*W + 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      checkOutput("bp_quo", int'(out_quo), int'(e.quo));
      checkOutput("bp_rem", int'(out_rem), int'(e.rem));
      in_valid = 1'b1; in_prod = 12'd35; in_opa = 6'd5;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_ready", int'(in_ready), 1);

    // Reset during CALC aborts the operation.
    applyStimulus(100, 7);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_quo", int'(out_quo), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(100, 7, 0);

    for (int n = 0; n < 40; n++) begin
      int a, p;
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      p = int'($urandom_range(0, 4095));
      runOp(p, a, int'($urandom_range(0, 3)));
    end

`ifdef MUL6_DIV_PERF_CNT_EN
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    runOp(35, 5, 0);
    runOp(4095, 63, 0);
    runOp(100, 7, 0);
    checkOutput("cnt_done", int'(cnt_done), 3);
    checkOutput("cnt_ovf", int'(cnt_ovf), 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checkOutput("cnt_done_clr", int'(cnt_done), 0);
    checkOutput("cnt_ovf_clr", int'(cnt_ovf), 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
